// File: rtl/lfsr_draw_if.sv
// Draw request/response bundle: req/ready handshake in, one-cycle valid pulse out
// with the drawn value and its fallback flag held until the next completion.
interface lfsr_draw_if #(
  parameter int unsigned OUT_W = 4
);
  logic             req;
  logic             ready;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             fallback;

  modport master (
    output req,
    input  ready,
    input  valid,
    input  value,
    input  fallback
  );

  modport slave (
    input  req,
    output ready,
    output valid,
    output value,
    output fallback
  );
endinterface

// File: rtl/lfsr_draw.sv
// Galois-free Fibonacci LFSR that draws bounded values by rejection sampling; each attempt
// costs SHIFTS+1 cycles, requests are taken only while idle (ready) and never queued.
module lfsr_draw #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
  parameter logic [WIDTH-1:0] SEED    = 16'h000F,
  parameter int unsigned      SHIFTS  = WIDTH,
  parameter int unsigned      OUT_W   = 4,
  parameter int unsigned      LIMIT   = 9,
  parameter int unsigned      MAX_TRY = 8
) (
  input  logic             clk,
  input  logic             restart,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             free_run,
  lfsr_draw_if.slave       draw,
  output logic [WIDTH-1:0] state
);

  localparam int unsigned CNT_W = $clog2(SHIFTS + 1);
  localparam int unsigned ATT_W = $clog2(MAX_TRY + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFTS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIFTS);
  localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);
  localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_TRY - 1);
  localparam logic [OUT_W:0]   LIM_EXT  = (OUT_W + 1)'(LIMIT);
  localparam bit               SINGLE   = (SHIFTS == 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             fallback_q, fallback_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] lfsr_n;
  logic [OUT_W-1:0] candidate;
  logic             cand_ok;

  always_comb begin
    lfsr_step  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    candidate  = lfsr_q[OUT_W-1:0];
    cand_ok    = ({1'b0, candidate} < LIM_EXT);

    fsm_d      = fsm_q;
    lfsr_n     = lfsr_q;
    cnt_d      = cnt_q;
    att_d      = att_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    valid_d    = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        if (draw.req) begin
          lfsr_n = lfsr_step;
          cnt_d  = CNT_ONE;
          att_d  = '0;
          fsm_d  = SINGLE ? CHECK : SHIFT;
        end else if (free_run) begin
          lfsr_n = lfsr_step;
        end
      end

      SHIFT: begin
        // A retry already spent its first shift on the CHECK edge, so it idles one
        // cycle at full count to keep every attempt at SHIFTS+1 cycles.
        if (cnt_q == CNT_FULL) begin
          fsm_d = CHECK;
        end else begin
          lfsr_n = lfsr_step;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST && att_q == '0) begin
            fsm_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (cand_ok) begin
          value_d    = candidate;
          fallback_d = 1'b0;
          valid_d    = 1'b1;
          fsm_d      = IDLE;
        end else if (att_q != ATT_LAST) begin
          att_d  = att_q + ATT_ONE;
          lfsr_n = lfsr_step;
          cnt_d  = CNT_ONE;
          fsm_d  = SHIFT;
        end else begin
          value_d    = '0;
          fallback_d = 1'b1;
          valid_d    = 1'b1;
          fsm_d      = IDLE;
        end
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase

    if (seed_load) begin
      lfsr_n     = seed_in;
      fsm_d      = IDLE;
      cnt_d      = '0;
      att_d      = '0;
      value_d    = value_q;
      fallback_d = fallback_q;
      valid_d    = 1'b0;
    end

    // The all-zero state is a lock-up point for an XOR LFSR; recover to SEED instead.
    lfsr_d = (lfsr_n == '0) ? SEED : lfsr_n;
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      fsm_q      <= IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      att_q      <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      att_q      <= att_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      valid_q    <= valid_d;
    end
  end

  assign draw.ready    = (fsm_q == IDLE);
  assign draw.valid    = valid_q;
  assign draw.value    = value_q;
  assign draw.fallback = fallback_q;
  assign state         = lfsr_q;

endmodule
